fetch_prefetch_queue: RTL and testbench

// - Instruction-fetch front end upstream of the IF/ID register: generates sequential PCs and

---
 rtl/fetch_prefetch_queue.sv | 162 ++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction-fetch front end ahead of the IF/ID register.
// Generates sequential fetch PCs, issues valid/ready requests to an in-order
// instruction memory, and buffers {pc, instr} pairs in a DEPTH-entry FIFO whose
// head is presented to decode. A redirect flushes the FIFO, restarts fetch at
// redirect_pc and discards every response still in flight.
// The number of FIFO entries plus requests in flight never exceeds DEPTH, so a
// returning response always finds room.
// Optional feature: define FETCH_BYPASS_EN to let a response that arrives while
// the FIFO is empty go straight to the outputs in the same cycle.
module fetch_prefetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INS_W    = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INS_W-1:0]  out_instr,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INS_W-1:0]  imem_resp_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W:0]    DEPTH_CAP = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

  // Fetch state
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_of_next_resp;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;

  // FIFO state
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] pc_mem  [DEPTH];
  logic [INS_W-1:0]  ins_mem [DEPTH];

  // Per-cycle decode
  logic [CNT_W:0]    in_use;
  logic              req_fire;
  logic              resp_keep;
  logic              fifo_empty;
  logic              bypass;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  resp_dec;

  // Request credit, response disposition and FIFO handshakes for this cycle.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    in_use         = {1'b0, count} + {1'b0, outstanding};
    imem_req_valid = !reset && !redirect_valid && (in_use < DEPTH_CAP);
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_keep      = imem_resp_valid && !redirect_valid && (drop_cnt == '0);
    resp_dec       = {{(CNT_W-1){1'b0}}, imem_resp_valid};
    fifo_empty     = (count == '0);
`ifdef FETCH_BYPASS_EN
    bypass         = !reset && resp_keep && fifo_empty && out_ready;
`else
    bypass         = 1'b0;
`endif
    push           = resp_keep && !bypass;
    pop            = !fifo_empty && out_ready && !redirect_valid;
  end

  // Head of the FIFO to decode; zero when nothing is valid.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = '0;
    if (!fifo_empty) begin
      out_valid = 1'b1;
      out_pc    = pc_mem[rd_ptr];
      out_instr = ins_mem[rd_ptr];
    end
`ifdef FETCH_BYPASS_EN
    else if (bypass) begin
      out_valid = 1'b1;
      out_pc    = pc_of_next_resp;
      out_instr = imem_resp_data;
    end
`endif
  end

  // Fetch PC, response PC tracking, credit counters and FIFO pointers.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      fetch_pc        <= RESET_PC;
      pc_of_next_resp <= RESET_PC;
      outstanding     <= '0;
      drop_cnt        <= '0;
      count           <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old path and is dropped.
      fetch_pc        <= redirect_pc;
      pc_of_next_resp <= redirect_pc;
      outstanding     <= outstanding - resp_dec;
      drop_cnt        <= outstanding - resp_dec;
      count           <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (resp_keep) begin
        pc_of_next_resp <= pc_of_next_resp + PC_STEP;
      end
      if (imem_resp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CNT_ONE;
      end
      case ({req_fire, imem_resp_valid})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // FIFO payload storage.
  always_ff @(posedge clock) begin
    // NOTE: the payload arrays are not reset; count gates every read, so their contents after reset never reach the outputs.
    if (push) begin
      pc_mem[wr_ptr]  <= pc_of_next_resp;
      ins_mem[wr_ptr] <= imem_resp_data;
    end
  end

  // The credit rule must make a push into a full FIFO impossible.
  no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: self-checking bench for fetch_prefetch_queue.
// An in-order memory model with per-request latency answers the DUT's requests.
// The reference model tags every accepted request with a redirect epoch; a
// response from an old epoch (or arriving during a redirect) is dropped, and a
// current one joins a queue of expected {pc} entries that decode should see.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] SALT     = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;

  fetch_prefetch_queue #(
    .ADDR_W  (32),
    .INS_W   (32),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Memory model and reference model state
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [31:0] model_q[$];
  int          epoch    = 0;
  logic [31:0] exp_addr = RESET_PC;

  // Values sampled from the DUT in the most recent step
  logic        smp_ov;
  logic [31:0] smp_pc;
  logic [31:0] smp_ins;
  logic        smp_rv;
  logic [31:0] smp_addr;

  // One clock cycle: drive inputs, compare with the model, advance everything.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit ordy,
                      input bit rrdy, input int lat);
    bit          resp;
    bit          exp_rv;
    bit          byp;
    bit          exp_ov;
    bit          acc;
    bit          do_pop;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
    mem_req_t    head;
    mem_req_t    fresh;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    out_ready       = ordy;
    imem_req_ready  = rrdy;
    resp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? (mem_q[0].addr ^ SALT) : 32'h0;
    #1;
    smp_ov   = out_valid;
    smp_pc   = out_pc;
    smp_ins  = out_instr;
    smp_rv   = imem_req_valid;
    smp_addr = imem_req_addr;
    exp_rv = !redir && ((model_q.size() + mem_q.size()) < DEPTH);
    byp    = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = resp && !redir && (model_q.size() == 0) && ordy && (mem_q[0].epoch == epoch);
`endif
    exp_ov  = (model_q.size() != 0) || byp;
    exp_pc  = (model_q.size() != 0) ? model_q[0] : (byp ? mem_q[0].addr : 32'h0);
    exp_ins = exp_ov ? (exp_pc ^ SALT) : 32'h0;
    check("req_valid", imem_req_valid, exp_rv);
    check("req_addr",  imem_req_addr,  exp_addr);
    check("out_valid", out_valid,      exp_ov);
    check("out_pc",    out_pc,         exp_pc);
    check("out_instr", out_instr,      exp_ins);
    acc    = imem_req_valid && imem_req_ready;
    do_pop = (model_q.size() != 0) && ordy && !redir;
    if (do_pop) void'(model_q.pop_front());
    if (resp) begin
      head = mem_q.pop_front();
      if (!redir && (head.epoch == epoch) && !byp) model_q.push_back(head.addr);
    end
    if (redir) begin
      model_q.delete();
      epoch++;
      exp_addr = rpc;
    end else if (exp_rv && rrdy) begin
      exp_addr = exp_addr + 32'd4;
    end
    if (acc) begin
      fresh.addr  = imem_req_addr;
      fresh.due   = cyc + lat;
      fresh.epoch = epoch;
      mem_q.push_back(fresh);
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  // Asynchronous reset in mid-cycle; the memory is reset along with the DUT.
  task automatic do_reset();
    #2;
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    out_ready       = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    #1;
    check("rst_out_valid", out_valid,      0);
    check("rst_out_pc",    out_pc,         0);
    check("rst_out_instr", out_instr,      0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr",  imem_req_addr,  RESET_PC);
    mem_q.delete();
    model_q.delete();
    epoch++;
    exp_addr = RESET_PC;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Wait (bounded) for the first valid output and compare its pc.
  task automatic expect_first(input string name, input logic [31:0] pc, input int lat);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, lat);
      if (smp_ov) begin
        seen = 1'b1;
        check(name, smp_pc, pc);
      end
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    bit          ordy;
    bit          ov;
    logic [31:0] pc;
    bit          rv;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[18];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Fill: 1-cycle memory, decode stalled for 12 cycles, then released.
    for (int i = 0; i < 18; i++) begin
      vecs[i].ordy = (i >= 12);
      vecs[i].ov   = (i >= 2);
      vecs[i].pc   = 32'h0;
      vecs[i].rv   = 1'b0;
      vecs[i].addr = 32'd16;
    end
    vecs[0].rv  = 1'b1; vecs[0].addr  = 32'd0;
    vecs[1].rv  = 1'b1; vecs[1].addr  = 32'd4;
    vecs[2].rv  = 1'b1; vecs[2].addr  = 32'd8;
    vecs[3].rv  = 1'b1; vecs[3].addr  = 32'd12;
    vecs[13].rv = 1'b1; vecs[13].pc   = 32'd4;
    vecs[14].rv = 1'b1; vecs[14].pc   = 32'd8;  vecs[14].addr = 32'd20;
    vecs[15].rv = 1'b1; vecs[15].pc   = 32'd12; vecs[15].addr = 32'd24;
    vecs[16].rv = 1'b1; vecs[16].pc   = 32'd16; vecs[16].addr = 32'd28;
    vecs[17].rv = 1'b1; vecs[17].pc   = 32'd20; vecs[17].addr = 32'd32;

    @(negedge clock);
    do_reset();

    // Table: fill to capacity under stall, drain in order, fetch resumes at 16.
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 32'h0, vecs[i].ordy, 1'b1, 1);
      check($sformatf("tbl%0d_ov", i),   smp_ov,   vecs[i].ov);
      check($sformatf("tbl%0d_pc", i),   smp_pc,   vecs[i].pc);
      check($sformatf("tbl%0d_ins", i),  smp_ins,  vecs[i].ov ? (vecs[i].pc ^ SALT) : 32'h0);
      check($sformatf("tbl%0d_rv", i),   smp_rv,   vecs[i].rv);
      check($sformatf("tbl%0d_addr", i), smp_addr, vecs[i].addr);
    end

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset();
    step(1'b0, 32'h0,   1'b1, 1'b1, 3);
    step(1'b0, 32'h0,   1'b1, 1'b1, 3);
    step(1'b1, 32'h100, 1'b1, 1'b1, 3);
    expect_first("drop_first_pc", 32'h100, 3);

    // Redirect in the same cycle as a response and a pop.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    step(1'b1, 32'h200, 1'b1, 1'b1, 1);
    step(1'b0, 32'h0,   1'b1, 1'b1, 1);
    check("flush_empty",   smp_ov,   0);
    check("flush_addr",    smp_addr, 32'h200);
    check("flush_rv",      smp_rv,   1);
    expect_first("flush_first_pc", 32'h200, 1);

    // Memory not ready: address held; then a redirect to the top of the space wraps.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 1);
      check("stall_addr", smp_addr, RESET_PC);
      check("stall_rv",   smp_rv,   1);
    end
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    check("wrap_top_addr", smp_addr, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    check("wrap_zero_addr", smp_addr, 32'h0);

    // Reset mid-stream, then restart at RESET_PC.
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 2);
    do_reset();
    expect_first("restart_pc", RESET_PC, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) == 0, 32'($urandom) & 32'hFFFF_FFFC,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
